spi_burst_ram: RTL and testbench
================================

# spi_burst_ram

Parametrised single-port memory behind the SPI slave's receive path, decoding 2-bit opcode + data words into address-set, write, and read commands. Successor to the fixed 8-bit/256-entry SPI RAM. Adds configurable width/depth, rx_valid-qualified command decode, address auto-increment for burst transfers, and a registered one-cycle tx_valid pulse aligned with read data. Sits between the SPI slave's deserialiser (din/rx_valid) and its serialiser (dout/tx_valid).

## Interface
Parameters:
- DATA_W, 8, memory word width and payload width of din
- ADDR_W, 8, address register width
- MEM_DEPTH, 256, number of words; must satisfy 2 <= MEM_DEPTH <= 2**ADDR_W

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  DATA_W+2  din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload
- rx_valid  input  1  din is a complete command this cycle
- dout  output  DATA_W  read data, registered
- tx_valid  output  1  one-cycle pulse; dout valid in the same cycle
- wr_addr  output  ADDR_W  current write pointer (debug/status)
- rd_addr  output  ADDR_W  current read pointer (debug/status)

## Operation
- Commands execute only in cycles with rx_valid=1; din is ignored when rx_valid=0.
- Opcode 00 SET_WA: wr_addr <= payload[ADDR_W-1:0] (zero-extended if DATA_W < ADDR_W).
- Opcode 01 WRITE: mem[wr_addr] <= payload; wr_addr advances (see Configuration).
- Opcode 10 SET_RA: rd_addr <= payload[ADDR_W-1:0].
- Opcode 11 READ: payload ignored; issues read of mem[rd_addr]; rd_addr advances.
- Two-state output FSM: IDLE -> RESP on accepted READ; RESP -> RESP on another accepted READ, otherwise IDLE. In RESP, tx_valid=1 and dout holds the fetched word.
- dout holds its last value when idle; only a READ updates it.
- Pointer advance: addr+1, wrapping MEM_DEPTH-1 -> 0 (not 2**ADDR_W-1 when depth is not a power of two).
- SET_WA/SET_RA payload >= MEM_DEPTH: pointer is loaded modulo-free as given; the access uses the value and wraps to 0 on the next advance. Out-of-range WRITE is dropped; out-of-range READ returns 0 and still pulses tx_valid.
- Memory contents are not reset.

## Timing
- Reset (rst=1 at an edge): dout=0, tx_valid=0, wr_addr=0, rd_addr=0, FSM=IDLE. Reset has priority over any command in the same cycle. A READ in flight is discarded, so no tx_valid follows reset.
- WRITE: memory updated at the edge where rx_valid=1. A READ of that address in the next cycle returns the new data.
- READ latency: command at edge N -> dout/tx_valid valid during cycle N+1 (after edge N).
- Back-to-back READs in consecutive cycles give consecutive tx_valid pulses with sequential addresses, one word per cycle.
- A pointer change by SET_* at edge N is used by a command at edge N+1.
- Exactly one command per cycle. No simultaneous read/write hazard exists.

## Configuration
- SPI_BURST_RAM_AUTO_INC_EN defined: WRITE advances wr_addr and READ advances rd_addr, each with MEM_DEPTH wrap.
- Not defined: pointers change only via SET_WA/SET_RA/reset. Repeated WRITE/READ target the same address, which is legacy-compatible behaviour.

## Test plan
- Reset then idle: rst=1 for 2 cycles -> dout=0, tx_valid=0, wr_addr=0, rd_addr=0. No tx_valid while rx_valid=0 with arbitrary din.
- Single write/read: SET_WA 0x10, WRITE 0xA5, SET_RA 0x10, READ -> the cycle after READ has dout=0xA5 and tx_valid=1 for exactly one cycle.
- Burst (AUTO_INC_EN): SET_WA 0xFE, WRITE 0x11,0x22,0x33; SET_RA 0xFE, 3 back-to-back READs -> tx_valid high 3 consecutive cycles with dout 0x11,0x22,0x33; addresses 0xFE,0xFF,0x00; final rd_addr=0x01.
- No auto-inc build: SET_WA 0x05, WRITE 0x01 then 0x02; SET_RA 0x05, READ twice -> both return 0x02; rd_addr stays 0x05.
- Non-power-of-two (MEM_DEPTH=200): SET_WA 199, WRITE 0x7E, WRITE 0x7F -> mem[199]=0x7E, mem[0]=0x7F; SET_RA 250, READ -> dout=0, tx_valid=1.
- Reset mid-read: READ at edge N, rst=1 at edge N+1 -> tx_valid=0 and dout=0 after N+1. rx_valid gating: opcode 01 with rx_valid=0 leaves memory unchanged.

Source files
------------

// File: rtl/spi_burst_ram_if.sv
// spi_burst_ram_if: command/response bus between the SPI slave's
// deserialiser/serialiser and the burst RAM.
// slave modport: the RAM side (takes commands, returns read data).
// master modport: the SPI side (issues commands, takes read data).
interface spi_burst_ram_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid
    );

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid
    );
endinterface

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: parametrised single-port RAM driven by 2-bit opcode
// commands (SET_WA, WRITE, SET_RA, READ) from an SPI slave receive path.
// Read data comes back one cycle after the READ with a tx_valid pulse.
// Optional feature macro: SPI_BURST_RAM_AUTO_INC_EN -- when defined, WRITE
// and READ advance their pointers (wrapping at MEM_DEPTH) for bursts;
// when undefined, pointers only move through SET_WA/SET_RA/reset.
module spi_burst_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    spi_burst_ram_if.slave    bus,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr
);

`ifdef SPI_BURST_RAM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    localparam logic [1:0] OP_SET_WA = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RA = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] payload_addr;
    logic              cmd_set_wa;
    logic              cmd_write;
    logic              cmd_set_ra;
    logic              cmd_read;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [ADDR_W-1:0] wr_next;
    logic [ADDR_W-1:0] rd_next;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] dout_q;

    assign opcode  = bus.din[DATA_W+1:DATA_W];
    assign payload = bus.din[DATA_W-1:0];

    // Pointer loads take the low ADDR_W payload bits, zero-extending narrow payloads
    generate
        if (DATA_W >= ADDR_W) begin : g_addr_trunc
            assign payload_addr = payload[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign payload_addr = {{(ADDR_W-DATA_W){1'b0}}, payload};
        end
    endgenerate

    // Decode the command; nothing happens unless rx_valid qualifies din
    always_comb begin
        cmd_set_wa = bus.rx_valid && (opcode == OP_SET_WA);
        cmd_write  = bus.rx_valid && (opcode == OP_WRITE);
        cmd_set_ra = bus.rx_valid && (opcode == OP_SET_RA);
        cmd_read   = bus.rx_valid && (opcode == OP_READ);
    end

    // Range checks and wrap-at-depth increments; out-of-range pointers wrap to 0
    always_comb begin
        wr_in_range = (wr_addr <= LAST_ADDR);
        rd_in_range = (rd_addr <= LAST_ADDR);
        wr_next     = (wr_addr >= LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
        rd_next     = (rd_addr >= LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
        wr_idx      = wr_addr[IDX_W-1:0];
        rd_idx      = rd_addr[IDX_W-1:0];
    end

    // Write and read pointers: reset, explicit load, or optional advance
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (cmd_set_wa) begin
                wr_addr <= payload_addr;
            end else if (cmd_write && AUTO_INC) begin
                wr_addr <= wr_next;
            end
            if (cmd_set_ra) begin
                rd_addr <= payload_addr;
            end else if (cmd_read && AUTO_INC) begin
                rd_addr <= rd_next;
            end
        end
    end

    // Memory array is not reset; out-of-range or reset-cycle writes are dropped
    always_ff @(posedge clk) begin
        if (!rst && cmd_write && wr_in_range) begin
            mem[wr_idx] <= payload;
        end
    end

    // Read data register: only a READ updates it, out-of-range reads return 0
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (cmd_read) begin
            dout_q <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

    // FSM state register; reset discards any response in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: every accepted READ produces a response cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = cmd_read ? RESP : IDLE;
            RESP:    next_state = cmd_read ? RESP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: tx_valid marks the cycle the fetched word sits on dout
    always_comb begin
        bus.tx_valid = (state == RESP);
        bus.dout     = dout_q;
    end

endmodule

// File: tb/tb_spi_burst_ram.sv
// tb_spi_burst_ram: table-driven bench for spi_burst_ram plus hand-written
// burst, non-auto-increment and non-power-of-two depth sequences.
// Expectations follow SPI_BURST_RAM_AUTO_INC_EN when it is defined.
module tb_spi_burst_ram;

`ifdef SPI_BURST_RAM_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [1:0] SWA = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] RD  = 2'b11;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [9:0] din;

    logic [7:0] wa256;
    logic [7:0] ra256;
    logic [7:0] wa200;
    logic [7:0] ra200;

    int errors;
    int checks;

    spi_burst_ram_if #(.DATA_W(8)) bus256 ();
    spi_burst_ram_if #(.DATA_W(8)) bus200 ();

    assign bus256.din      = din;
    assign bus256.rx_valid = rx_valid;
    assign bus200.din      = din;
    assign bus200.rx_valid = rx_valid;

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) u_dut256 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus256.slave),
        .wr_addr (wa256),
        .rd_addr (ra256)
    );

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) u_dut200 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus200.slave),
        .wr_addr (wa200),
        .rd_addr (ra200)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       rxv;
        logic [1:0] op;
        logic [7:0] pl;
        logic       ex_tx;
        logic [7:0] ex_dout;
        logic [7:0] ex_wa;
        logic [7:0] ex_ra;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic v, logic [1:0] o,
                                logic [7:0] p, logic t, logic [7:0] d,
                                logic [7:0] w, logic [7:0] a);
        vec_t x;
        x.name = n; x.rst = r; x.rxv = v; x.op = o; x.pl = p;
        x.ex_tx = t; x.ex_dout = d; x.ex_wa = w; x.ex_ra = a;
        return x;
    endfunction

    // Drive one cycle of inputs at the falling edge, then sample 1 after rising edge
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [1:0] o, input logic [7:0] p);
        @(negedge clk);
        rst      = r;
        rx_valid = v;
        din      = {o, p};
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string n, input string f,
                       input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", n, f, got, exp);
        end
    endtask

    // sel 0 = depth-256 instance, sel 1 = depth-200 instance
    task automatic checkOutput(input string n, input int sel, input logic t,
                               input logic [7:0] d, input logic [7:0] w,
                               input logic [7:0] a);
        if (sel == 0) begin
            cmp(n, "tx_valid", {7'd0, bus256.tx_valid}, {7'd0, t});
            cmp(n, "dout", bus256.dout, d);
            cmp(n, "wr_addr", wa256, w);
            cmp(n, "rd_addr", ra256, a);
        end else begin
            cmp(n, "tx_valid", {7'd0, bus200.tx_valid}, {7'd0, t});
            cmp(n, "dout", bus200.dout, d);
            cmp(n, "wr_addr", wa200, w);
            cmp(n, "rd_addr", ra200, a);
        end
    endtask

    task automatic step(input string n, input int sel, input logic [1:0] o,
                        input logic [7:0] p, input logic t, input logic [7:0] d,
                        input logic [7:0] w, input logic [7:0] a);
        applyStimulus(1'b0, 1'b1, o, p);
        checkOutput(n, sel, t, d, w, a);
    endtask

    initial begin
        logic [7:0] i1;
        i1       = AUTO ? 8'h01 : 8'h00;
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = '0;

        vecs.push_back(mk("rst0",      1, 0, SWA, 8'h00, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("rst1",      1, 0, SWA, 8'h00, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("idle_wr",   0, 0, WR,  8'h5A, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("idle_rd",   0, 0, RD,  8'hC3, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("set_wa",    0, 1, SWA, 8'h10, 0, 8'h00, 8'h10, 8'h00));
        vecs.push_back(mk("write",     0, 1, WR,  8'hA5, 0, 8'h00, 8'h10 + i1, 8'h00));
        vecs.push_back(mk("set_ra",    0, 1, SRA, 8'h10, 0, 8'h00, 8'h10 + i1, 8'h10));
        vecs.push_back(mk("read",      0, 1, RD,  8'h77, 1, 8'hA5, 8'h10 + i1, 8'h10 + i1));
        vecs.push_back(mk("after_rd",  0, 0, RD,  8'h00, 0, 8'hA5, 8'h10 + i1, 8'h10 + i1));
        vecs.push_back(mk("set_wa2",   0, 1, SWA, 8'h10, 0, 8'hA5, 8'h10, 8'h10 + i1));
        vecs.push_back(mk("gated_wr",  0, 0, WR,  8'hEE, 0, 8'hA5, 8'h10, 8'h10 + i1));
        vecs.push_back(mk("set_ra2",   0, 1, SRA, 8'h10, 0, 8'hA5, 8'h10, 8'h10));
        vecs.push_back(mk("read2",     0, 1, RD,  8'h00, 1, 8'hA5, 8'h10, 8'h10 + i1));
        vecs.push_back(mk("idle2",     0, 0, SWA, 8'h00, 0, 8'hA5, 8'h10, 8'h10 + i1));
        vecs.push_back(mk("set_ra3",   0, 1, SRA, 8'h10, 0, 8'hA5, 8'h10, 8'h10));
        vecs.push_back(mk("read3",     0, 1, RD,  8'h00, 1, 8'hA5, 8'h10, 8'h10 + i1));
        vecs.push_back(mk("rst_mid",   1, 1, RD,  8'h00, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("post_rst",  0, 0, RD,  8'h00, 0, 8'h00, 8'h00, 8'h00));

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst, vecs[k].rxv, vecs[k].op, vecs[k].pl);
            checkOutput(vecs[k].name, 0, vecs[k].ex_tx, vecs[k].ex_dout,
                        vecs[k].ex_wa, vecs[k].ex_ra);
            checkOutput({vecs[k].name, "_d200"}, 1, vecs[k].ex_tx, vecs[k].ex_dout,
                        vecs[k].ex_wa, vecs[k].ex_ra);
        end

        if (AUTO) begin
            $display("[TB] burst sequence with auto-increment");
            step("b_swa", 0, SWA, 8'hFE, 0, 8'h00, 8'hFE, 8'h00);
            step("b_w1",  0, WR,  8'h11, 0, 8'h00, 8'hFF, 8'h00);
            step("b_w2",  0, WR,  8'h22, 0, 8'h00, 8'h00, 8'h00);
            step("b_w3",  0, WR,  8'h33, 0, 8'h00, 8'h01, 8'h00);
            step("b_sra", 0, SRA, 8'hFE, 0, 8'h00, 8'h01, 8'hFE);
            step("b_r1",  0, RD,  8'h00, 1, 8'h11, 8'h01, 8'hFF);
            step("b_r2",  0, RD,  8'h00, 1, 8'h22, 8'h01, 8'h00);
            step("b_r3",  0, RD,  8'h00, 1, 8'h33, 8'h01, 8'h01);
            applyStimulus(1'b0, 1'b0, RD, 8'h00);
            checkOutput("b_idle", 0, 0, 8'h33, 8'h01, 8'h01);
        end else begin
            $display("[TB] fixed-pointer sequence");
            step("n_swa", 0, SWA, 8'h05, 0, 8'h00, 8'h05, 8'h00);
            step("n_w1",  0, WR,  8'h01, 0, 8'h00, 8'h05, 8'h00);
            step("n_w2",  0, WR,  8'h02, 0, 8'h00, 8'h05, 8'h00);
            step("n_sra", 0, SRA, 8'h05, 0, 8'h00, 8'h05, 8'h05);
            step("n_r1",  0, RD,  8'h00, 1, 8'h02, 8'h05, 8'h05);
            step("n_r2",  0, RD,  8'h00, 1, 8'h02, 8'h05, 8'h05);
            applyStimulus(1'b0, 1'b0, RD, 8'h00);
            checkOutput("n_idle", 0, 0, 8'h02, 8'h05, 8'h05);
        end

        $display("[TB] depth-200 wrap and out-of-range sequence");
        begin
            logic [7:0] wa_a, wa_b, ra_a, ra_b, ra_c, d_first;
            wa_a    = AUTO ? 8'h00 : 8'hC7;
            wa_b    = AUTO ? 8'h01 : 8'hC7;
            ra_a    = AUTO ? 8'h00 : 8'hC7;
            ra_b    = AUTO ? 8'h01 : 8'hC7;
            ra_c    = AUTO ? 8'h00 : 8'hFA;
            d_first = AUTO ? 8'h7E : 8'h7F;
            applyStimulus(1'b0, 1'b1, SWA, 8'd199);
            cmp("d200_swa", "wr_addr", wa200, 8'hC7);
            applyStimulus(1'b0, 1'b1, WR, 8'h7E);
            cmp("d200_w1", "wr_addr", wa200, wa_a);
            applyStimulus(1'b0, 1'b1, WR, 8'h7F);
            cmp("d200_w2", "wr_addr", wa200, wa_b);
            applyStimulus(1'b0, 1'b1, SRA, 8'd199);
            cmp("d200_sra", "rd_addr", ra200, 8'hC7);
            cmp("d200_sra", "tx_valid", {7'd0, bus200.tx_valid}, 8'h00);
            applyStimulus(1'b0, 1'b1, RD, 8'h00);
            cmp("d200_r1", "tx_valid", {7'd0, bus200.tx_valid}, 8'h01);
            cmp("d200_r1", "dout", bus200.dout, d_first);
            cmp("d200_r1", "rd_addr", ra200, ra_a);
            applyStimulus(1'b0, 1'b1, RD, 8'h00);
            cmp("d200_r2", "tx_valid", {7'd0, bus200.tx_valid}, 8'h01);
            cmp("d200_r2", "dout", bus200.dout, 8'h7F);
            cmp("d200_r2", "rd_addr", ra200, ra_b);
            applyStimulus(1'b0, 1'b1, SRA, 8'd250);
            cmp("d200_sra_oor", "rd_addr", ra200, 8'hFA);
            cmp("d200_sra_oor", "tx_valid", {7'd0, bus200.tx_valid}, 8'h00);
            cmp("d200_sra_oor", "dout", bus200.dout, 8'h7F);
            applyStimulus(1'b0, 1'b1, RD, 8'h00);
            cmp("d200_r_oor", "tx_valid", {7'd0, bus200.tx_valid}, 8'h01);
            cmp("d200_r_oor", "dout", bus200.dout, 8'h00);
            cmp("d200_r_oor", "rd_addr", ra200, ra_c);
            applyStimulus(1'b0, 1'b0, RD, 8'h00);
            cmp("d200_idle", "tx_valid", {7'd0, bus200.tx_valid}, 8'h00);
            cmp("d200_idle", "dout", bus200.dout, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
